// File: rtl/adxl_spi_pkg.sv
// adxl_spi_pkg
// Shared definitions for the ADXL-style SPI responder: SPI command codes,
// register addresses, the transaction FSM state type and a helper that tells
// whether an address accepts SPI writes.
// Optional feature macro used by the responder: ADXL_SPI_RESP_SOFT_RESET_EN.
package adxl_spi_pkg;

  // SPI command bytes
  localparam logic [7:0] CMD_READ  = 8'h0A;
  localparam logic [7:0] CMD_WRITE = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  // Register map
  localparam logic [7:0] ADDR_STATUS     = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
  localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
  localparam logic [7:0] ADDR_INTMAP1    = 8'h2A;
  localparam logic [7:0] ADDR_INTMAP2    = 8'h2B;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_t;

  // ID registers and the sample registers are owned by the responder itself,
  // so SPI writes to them are silently dropped.
  function automatic logic is_writable(input logic [7:0] addr);
    return !((addr <= 8'h02) || ((addr >= ADDR_XDATA_L) && (addr <= ADDR_ZDATA_H)));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings the asynchronous SPI pins into the clk domain through 2-FF
// synchronizers and derives single-cycle edge strobes from the synced copies.
// Ports:
//   clk, rst              system clock, synchronous active-low reset
//   sclk, cs_n, mosi      raw SPI pins
//   sclk_rise, sclk_fall  one-cycle strobes on synced sclk edges
//   cs_fall, cs_rise      one-cycle strobes on synced cs_n edges
//   cs_n_sync, mosi_sync  synchronized levels
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_sync,
  output logic mosi_sync
);

  // Bits [1:0] are the synchronizer, bit [2] is the previous synced value.
  // mosi uses the same depth as sclk so both stay aligned at a rising edge.
  logic [2:0] sclk_pipe;
  logic [2:0] cs_pipe;
  logic [1:0] mosi_pipe;

  // Synchronizer and edge history; cs_n idles high so a reset never looks
  // like the start of a transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_pipe <= 3'b000;
      cs_pipe   <= 3'b111;
      mosi_pipe <= 2'b00;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], sclk};
      cs_pipe   <= {cs_pipe[1:0], cs_n};
      mosi_pipe <= {mosi_pipe[0], mosi};
    end
  end

  assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
  assign sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];
  assign cs_fall   = ~cs_pipe[1] & cs_pipe[2];
  assign cs_rise   = cs_pipe[1] & ~cs_pipe[2];
  assign cs_n_sync = cs_pipe[1];
  assign mosi_sync = mosi_pipe[1];

endmodule

// File: rtl/adxl_spi_responder.sv
// adxl_spi_responder
// SPI mode-0 responder that stands in for the accelerometer of a PmodACL2
// link. Decodes command, address and data bytes, serves register reads
// (with auto-incrementing burst) and accepts register writes. Axis samples
// from a stimulus source land in 0x0E-0x13; samples arriving mid-transaction
// are held back until chip select rises so a burst read is never torn.
// Ports:
//   clk, rst                    system clock (>= 8x sclk), sync active-low reset
//   sclk, cs_n, mosi            SPI inputs (oversampled in clk domain)
//   miso, miso_oe               SPI data out and its enable
//   sample_x/y/z, sample_valid  new axis sample and its capture strobe
//   int1, int2                  level interrupts from STATUS & INTMAPx
//   measure_en                  POWER_CTL[1:0] == 2'b10
// Optional feature macro: ADXL_SPI_RESP_SOFT_RESET_EN (0x52 written to
// 0x1F clears the register file and any pending sample).
module adxl_spi_responder
  import adxl_spi_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2,
  parameter int         REG_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic        int2,
  output logic        measure_en
);

  localparam int AW = $clog2(REG_DEPTH);
  localparam logic [AW-1:0] A_STATUS = AW'(ADDR_STATUS);
  localparam logic [AW-1:0] A_XL     = AW'(ADDR_XDATA_L);
  localparam logic [AW-1:0] A_ZH     = AW'(ADDR_ZDATA_H);
  localparam logic [AW-1:0] A_IM1    = AW'(ADDR_INTMAP1);
  localparam logic [AW-1:0] A_IM2    = AW'(ADDR_INTMAP2);
  localparam logic [AW-1:0] A_PWR    = AW'(ADDR_POWER_CTL);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_sync, mosi_sync;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_n_sync (cs_n_sync),
    .mosi_sync (mosi_sync)
  );

  spi_state_t    state, state_next;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_in;
  logic [7:0]    rx_byte;
  logic          is_write;
  logic [AW-1:0] ptr;
  logic [7:0]    tx_shift;
  logic [7:0]    regs [REG_DEPTH];

  logic          in_shift, byte_done, addr_done, data_done;
  logic          wr_en, load_en, tx_step;
  logic [AW-1:0] load_addr;

  logic          pend_valid;
  logic [47:0]   pend_data;
  logic          cap_direct, pend_apply, cap_any;
  logic [47:0]   cap_data;
  logic          soft_clr;

  // The byte completing on this sclk rise includes the bit being sampled now.
  assign rx_byte   = {shift_in, mosi_sync};
  assign in_shift  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign byte_done = sclk_rise && in_shift && (bit_cnt == 3'd7) && !cs_rise;
  assign addr_done = byte_done && (state == ST_ADDR);
  assign data_done = byte_done && (state == ST_DATA);
  assign wr_en     = data_done && is_write;
  assign load_en   = (addr_done || data_done) && !is_write;
  assign load_addr = addr_done ? rx_byte[AW-1:0] : ptr + AW'(1);
  assign tx_step   = (state == ST_DATA) && !is_write && sclk_fall;

  // Samples go straight in while cs_n is high; a held sample is applied one
  // cycle after cs_n rises. A fresh direct sample supersedes a held one.
  assign cap_direct = sample_valid && cs_n_sync;
  assign pend_apply = pend_valid && cs_n_sync && !cs_rise;
  assign cap_any    = cap_direct || pend_apply;
  assign cap_data   = cap_direct ? {sample_z, sample_y, sample_x} : pend_data;

  assign measure_en = (regs[A_PWR][1:0] == 2'b10);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // FSM next-state: cs_n rising always aborts back to IDLE
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if ((rx_byte == CMD_READ) || (rx_byte == CMD_WRITE)) state_next = ST_ADDR;
            else                                                 state_next = ST_IGNORE;
          end
        end
        ST_ADDR: if (byte_done) state_next = ST_DATA;
        default: state_next = state;
      endcase
    end
  end

  // Bit/byte datapath: receive shifter, pointer and transmit shifter.
  // miso is driven from the tx shifter on sclk falls only in a DATA read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
      is_write <= 1'b0;
      ptr      <= '0;
      tx_shift <= 8'd0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      miso_oe <= ~cs_n_sync;
      if (cs_fall) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise && in_shift) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= rx_byte[6:0];
      end
      if (byte_done && (state == ST_CMD)) is_write <= (rx_byte == CMD_WRITE);
      if (addr_done)      ptr <= rx_byte[AW-1:0];
      else if (data_done) ptr <= ptr + AW'(1);
      if (load_en)      tx_shift <= regs[load_addr];
      else if (tx_step) tx_shift <= {tx_shift[6:0], 1'b0};
      if (tx_step)                 miso <= tx_shift[7];
      else if (state != ST_DATA)   miso <= 1'b0;
    end
  end

  // Register file. Ordering matters: SPI write, then the DATA_READY clear
  // on loading ZDATA_H, then sample capture, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (!rst || soft_clr) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
      regs[0] <= DEVID_AD;
      regs[1] <= DEVID_MST;
      regs[2] <= PARTID;
    end else begin
      if (wr_en && is_writable(8'(ptr))) regs[ptr] <= rx_byte;
      if (load_en && (load_addr == A_ZH)) regs[A_STATUS][0] <= 1'b0;
      if (cap_any) begin
        for (int i = 0; i < 6; i++) regs[A_XL + AW'(i)] <= cap_data[8*i +: 8];
        regs[A_STATUS][0] <= 1'b1;
      end
    end
  end

  // Holding register for samples that arrive while a transaction is open;
  // the newest one wins.
  always_ff @(posedge clk) begin
    if (!rst || soft_clr) begin
      pend_valid <= 1'b0;
      pend_data  <= 48'd0;
    end else if (sample_valid && !cs_n_sync) begin
      pend_valid <= 1'b1;
      pend_data  <= {sample_z, sample_y, sample_x};
    end else if (cap_any) begin
      pend_valid <= 1'b0;
    end
  end

`ifdef ADXL_SPI_RESP_SOFT_RESET_EN
  // Soft reset takes effect the cycle after the key byte is written;
  // the transaction FSM is deliberately left running.
  always_ff @(posedge clk) begin
    if (!rst) soft_clr <= 1'b0;
    else      soft_clr <= wr_en && (8'(ptr) == ADDR_SOFT_RESET) && (rx_byte == SOFT_RESET_KEY);
  end
`else
  assign soft_clr = 1'b0;
`endif

  // Interrupts: bits [6:0] of STATUS & INTMAPx, bit 7 of INTMAPx flips polarity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      int1 <= 1'b0;
      int2 <= 1'b0;
    end else begin
      int1 <= (|(regs[A_STATUS][6:0] & regs[A_IM1][6:0])) ^ regs[A_IM1][7];
      int2 <= (|(regs[A_STATUS][6:0] & regs[A_IM2][6:0])) ^ regs[A_IM2][7];
    end
  end

endmodule

// File: tb/tb_adxl_spi_responder.sv
// tb_adxl_spi_responder
// Directed bench for adxl_spi_responder: drives SPI mode-0 transactions with
// sclk at 1/16 of clk and compares returned bytes and status outputs against
// hand-computed values. Exercises the soft-reset path when
// ADXL_SPI_RESP_SOFT_RESET_EN is defined.
module tb_adxl_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] sample_x = 16'h0;
  logic [15:0] sample_y = 16'h0;
  logic [15:0] sample_z = 16'h0;
  logic        sample_valid = 1'b0;
  logic        miso, miso_oe, int1, int2, measure_en;

  int checks = 0;
  int failures = 0;
  logic [7:0] rxb;

  always #5 clk = ~clk;

  adxl_spi_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1),
    .int2         (int2),
    .measure_en   (measure_en)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle sample strobe, launched on a falling clk edge
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z);
    @(negedge clk);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic spiStart();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic spiEnd();
    #80;
    cs_n = 1'b1;
    #160;
  endtask

  // Mode 0: mosi set while sclk low, both sides sample on the rise
  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #80;
      sclk = 1'b1;
      rx[i] = miso;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] r;
    spiStart();
    spiByte(8'h0B, r);
    spiByte(addr, r);
    spiByte(data, r);
    spiEnd();
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr,
                           input logic [7:0] expected);
    logic [7:0] r;
    spiStart();
    spiByte(8'h0A, r);
    spiByte(addr, r);
    spiByte(8'h00, r);
    spiEnd();
    checkOutput(tag, {8'h00, r}, {8'h00, expected});
  endtask

  initial begin
    logic [7:0] exp_id [3]     = '{8'hAD, 8'h1D, 8'hF2};
    logic [7:0] exp_sample [6] = '{8'h34, 8'h12, 8'hDC, 8'hFE, 8'h00, 8'h04};

    $display("[TB] start");
    repeat (4) @(negedge clk);
    checkOutput("rst_miso",       {15'd0, miso},       16'd0);
    checkOutput("rst_miso_oe",    {15'd0, miso_oe},    16'd0);
    checkOutput("rst_int1",       {15'd0, int1},       16'd0);
    checkOutput("rst_int2",       {15'd0, int2},       16'd0);
    checkOutput("rst_measure_en", {15'd0, measure_en}, 16'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // ID registers in a 3-byte burst
    spiStart();
    checkOutput("miso_oe_active", {15'd0, miso_oe}, 16'd1);
    spiByte(8'h0A, rxb);
    spiByte(8'h00, rxb);
    for (int i = 0; i < 3; i++) begin
      spiByte(8'h00, rxb);
      checkOutput($sformatf("id_burst[%0d]", i), {8'h00, rxb}, {8'h00, exp_id[i]});
    end
    spiEnd();
    checkOutput("miso_oe_idle", {15'd0, miso_oe}, 16'd0);

    // Ordinary write/read and a dropped write to a sample register
    writeReg(8'h2D, 8'h0A);
    readCheck("power_ctl", 8'h2D, 8'h0A);
    checkOutput("measure_en_on", {15'd0, measure_en}, 16'd1);
    writeReg(8'h0E, 8'h55);
    readCheck("xdata_l_ro", 8'h0E, 8'h00);

    // Sample capture and burst read of all axes
    applyStimulus(16'h1234, 16'hFEDC, 16'h0400);
    readCheck("status_ready", 8'h0B, 8'h01);
    spiStart();
    spiByte(8'h0A, rxb);
    spiByte(8'h0E, rxb);
    for (int i = 0; i < 6; i++) begin
      spiByte(8'h00, rxb);
      checkOutput($sformatf("sample_burst[%0d]", i), {8'h00, rxb}, {8'h00, exp_sample[i]});
    end
    spiEnd();
    readCheck("status_cleared", 8'h0B, 8'h00);

    // New sample mid-burst must not tear the burst
    spiStart();
    spiByte(8'h0A, rxb);
    spiByte(8'h0E, rxb);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) applyStimulus(16'h1111, 16'h2222, 16'h3333);
      spiByte(8'h00, rxb);
      checkOutput($sformatf("torn_burst[%0d]", i), {8'h00, rxb}, {8'h00, exp_sample[i]});
    end
    spiEnd();
    spiStart();
    spiByte(8'h0A, rxb);
    spiByte(8'h0E, rxb);
    spiByte(8'h00, rxb);
    checkOutput("pending_x_l", {8'h00, rxb}, 16'h0011);
    spiByte(8'h00, rxb);
    checkOutput("pending_x_h", {8'h00, rxb}, 16'h0011);
    spiEnd();
    readCheck("status_pending", 8'h0B, 8'h01);

    // Interrupt on DATA_READY, cleared by loading ZDATA_H
    readCheck("zdata_h_pending", 8'h13, 8'h33);
    readCheck("status_after_zh", 8'h0B, 8'h00);
    writeReg(8'h2A, 8'h01);
    checkOutput("int1_idle", {15'd0, int1}, 16'd0);
    applyStimulus(16'h0505, 16'h0606, 16'h0707);
    @(negedge clk);
    checkOutput("int1_set", {15'd0, int1}, 16'd1);
    checkOutput("int2_unmapped", {15'd0, int2}, 16'd0);
    readCheck("zdata_h_int", 8'h13, 8'h07);
    checkOutput("int1_cleared", {15'd0, int1}, 16'd0);

    // Pointer wraps 0x3F -> 0x00; the wrapped write hits read-only DEVID
    spiStart();
    spiByte(8'h0B, rxb);
    spiByte(8'h3F, rxb);
    spiByte(8'hA5, rxb);
    spiByte(8'h5A, rxb);
    spiEnd();
    spiStart();
    spiByte(8'h0A, rxb);
    spiByte(8'h3F, rxb);
    spiByte(8'h00, rxb);
    checkOutput("wrap_3f", {8'h00, rxb}, 16'h00A5);
    spiByte(8'h00, rxb);
    checkOutput("wrap_00_ro", {8'h00, rxb}, 16'h00AD);
    spiEnd();

    // Partial data byte is discarded
    spiStart();
    spiByte(8'h0B, rxb);
    spiByte(8'h30, rxb);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      #80;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
    spiEnd();
    readCheck("abort_no_write", 8'h30, 8'h00);

    // Unknown command: miso silent, no register change
    spiStart();
    spiByte(8'h77, rxb);
    spiByte(8'h2D, rxb);
    checkOutput("badcmd_miso0", {8'h00, rxb}, 16'h0000);
    spiByte(8'hFF, rxb);
    checkOutput("badcmd_miso1", {8'h00, rxb}, 16'h0000);
    spiEnd();
    readCheck("badcmd_power_ctl", 8'h2D, 8'h0A);

`ifdef ADXL_SPI_RESP_SOFT_RESET_EN
    writeReg(8'h1F, 8'h52);
    readCheck("soft_reset_power_ctl", 8'h2D, 8'h00);
`else
    writeReg(8'h1F, 8'h52);
    readCheck("soft_reset_plain_reg", 8'h1F, 8'h52);
    readCheck("soft_reset_power_ctl", 8'h2D, 8'h0A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adxl_spi_responder.md
Name: adxl_spi_responder

Overview:
- SPI-mode-0 responder modelling the accelerometer side of the PmodACL2 link: decodes command byte, address byte, then data bytes; serves register reads and accepts register writes.
- Lets the accelerometer-side SPI controller and glove pipeline run in simulation or FPGA loopback without the physical sensor.
- Fed by a stimulus/sample source.
- Drives an interrupt line like the real part.
- All SPI inputs are oversampled in the clk domain; clk must be at least 8x sclk.

Parameters:
- DEVID_AD, 8'hAD, value of reg 0x00
- DEVID_MST, 8'h1D, value of reg 0x01
- PARTID, 8'hF2, value of reg 0x02
- REG_DEPTH, 64, register file size in bytes; addresses wrap modulo REG_DEPTH

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- sclk  in  1  SPI clock, CPOL=0
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  SPI data in, MSB first
- miso  out  1  SPI data out, MSB first
- miso_oe  out  1  high while cs_n (synchronized) low
- sample_x, sample_y, sample_z  in  16 each  new axis sample
- sample_valid  in  1  one-cycle strobe; captures the sample_* inputs
- int1  out  1  interrupt, level, active high
- int2  out  1  interrupt, level, active high
- measure_en  out  1  POWER_CTL[1:0]==2'b10

Behaviour:
- Input sync and edge detect:
  - sclk, cs_n and mosi pass through 2-FF synchronizers.
  - Rising/falling edge of sclk and falling/rising edge of cs_n are detected from the synced copies.
- Reset (rst=0):
  - miso=0, miso_oe=0, int1=0, int2=0, measure_en=0.
  - All registers 0, except 0x00-0x02, which hold the parameter values. 0x00-0x02 are read-only.
  - FSM=IDLE, bit counter=0, pending sample cleared.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE -> CMD on cs_n fall. Bit counter cleared.
  - CMD:
    - Shift mosi on each sclk rise.
    - After the 8th bit: 0x0A -> ADDR (read); 0x0B -> ADDR (write); anything else -> IGNORE.
  - ADDR:
    - After the 8th bit, latch ptr = addr mod REG_DEPTH, then go to DATA.
    - For a read, load the tx shifter with reg[ptr]. miso presents bit7 at the next sclk fall.
  - DATA, write:
    - After each 8th rising edge, write the byte to reg[ptr] (writes to 0x00-0x02 and 0x0E-0x13 are dropped), then ptr += 1.
  - DATA, read:
    - miso updates on each sclk fall.
    - After the 8th rising edge, ptr += 1 and reg[ptr] is loaded for the next byte.
  - ptr wraps 0x3F -> 0x00.
  - IGNORE: miso held 0 until cs_n rises.
  - Any state -> IDLE on cs_n rise. A partial byte (<8 bits) is discarded with no write.
- Sample capture:
  - On sample_valid with cs_n high: write 0x0E-0x13 = x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]. Set STATUS (0x0B) bit0 DATA_READY.
  - sample_valid during a transaction stores the sample as pending. It is applied in the cycle after the cs_n rise, so a burst read is never torn. A later pending sample overwrites an earlier one.
- DATA_READY clear: cleared when 0x13 is loaded into the tx shifter. If a set and a clear happen in the same cycle, set wins.
- Interrupts:
  - int1 = |(STATUS & INTMAP1(0x2A)) masked to bits [6:0].
  - int2 is the same, using INTMAP2(0x2B).
  - Bit 7 of INTMAPx inverts polarity.
  - Both are registered, so they lag the register change by 1 cycle.
- Latency:
  - A register write becomes visible in the clk cycle after the 8th synced sclk rise of the data byte.
  - Total latency from the pin: 3 cycles.

Optional Feature:
- Macro: ADXL_SPI_RESP_SOFT_RESET_EN.
- When defined:
  - Writing 8'h52 to 0x1F (SOFT_RESET) resets the register file, DATA_READY and the pending sample to reset values in the cycle after the write, same as rst.
  - The FSM continues the current transaction: ptr still increments.
- When undefined: 0x1F is an ordinary read/write register with no side effect.

Decomposition:
- Shared package `adxl_spi_pkg`:
  - Command constants CMD_READ=8'h0A, CMD_WRITE=8'h0B, CMD_FIFO=8'h0D.
  - Register addresses (XDATA_L 0x0E, STATUS 0x0B, SOFT_RESET 0x1F, INTMAP1 0x2A, INTMAP2 0x2B, POWER_CTL 0x2D).
  - FSM state enum.
- One natural sub-module, `spi_sync_edge`: 2-FF synchronizers plus edge detectors for sclk and cs_n.

Test Plan:
- Reset: release rst, then read 0x00..0x02 in a 3-byte burst -> MISO returns 0xAD, 0x1D, 0xF2; miso_oe high only while cs_n low.
- Write then read: write 0x0A to 0x2D, then read 0x2D -> 0x0A and measure_en=1. A write of 0x55 to 0x0E is ignored; read of 0x0E stays 0x00.
- Sample and burst read:
  - sample_valid with x=0x1234, y=0xFEDC, z=0x0400.
  - Burst read from 0x0E -> 34 12 DC FE 00 04.
  - STATUS bit0 goes 1 before the read, 0 after.
- Torn-read guard:
  - Assert sample_valid (x=0x1111) in the middle of a burst read of 0x0E..0x13 -> the burst returns the old data.
  - The next read returns 0x11, 0x11.
- Interrupt and wrap:
  - INTMAP1=0x01, then sample_valid -> int1 rises within 2 cycles and falls after 0x13 is read.
  - Write a 2-byte burst starting at 0x3F -> the second byte lands at 0x00 and is dropped because 0x00 is read-only.
- Abort and bad command:
  - cs_n rises after 5 data bits -> no write.
  - Command 0x77 -> MISO stays 0 and no register changes.
  - With ADXL_SPI_RESP_SOFT_RESET_EN, writing 0x52 to 0x1F clears 0x2D to 0x00.
